// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shift register with load/ready handshake,
// shift-enable stall and back-to-back reload on the final bit.
module piso_shift_register #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             SRCLR_N,
    input  logic [WIDTH-1:0] PI,
    input  logic             LOAD,
    input  logic             SHEN,
    output logic             READY,
    output logic             SO,
    output logic             SO_VALID,
    output logic             LAST
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  sreg, sreg_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              accept;

    // Outputs are decoded from registered state only, so PI/LOAD never reach SO.
    always_comb begin
        SO_VALID = (state == SHIFT);
        LAST     = (state == SHIFT) && (cnt == CNT_LAST);
        READY    = (state == IDLE) || (LAST && SHEN);
        SO       = 1'b0;
        if (state == SHIFT) begin
            SO = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
        end
        accept   = LOAD && READY;
    end

    // Next-state, shift-register and counter update.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        if (accept) begin
            state_nxt = SHIFT;
            sreg_nxt  = PI;
            cnt_nxt   = '0;
        end else if ((state == SHIFT) && SHEN) begin
            if (LAST) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt   = cnt + CW'(1);
            end
            if (MSB_FIRST != 0) begin
                sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
            end else begin
                sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
            end
        end
    end

    // State register with synchronous active-low clear taking priority.
    always_ff @(posedge CLK) begin
        if (!SRCLR_N) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_piso_shift_register.sv
// Directed, table-driven check of piso_shift_register (MSB-first instance)
// plus a hand-written LSB-first sequence on a second instance.
module tb_piso_shift_register;

    logic       CLK;
    logic       a_rst_n, a_load, a_shen;
    logic [3:0] a_pi;
    logic       a_ready, a_so, a_valid, a_last;
    logic       b_rst_n, b_load, b_shen;
    logic [3:0] b_pi;
    logic       b_ready, b_so, b_valid, b_last;

    int n_vec;
    int n_err;

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
        .CLK(CLK), .SRCLR_N(a_rst_n), .PI(a_pi), .LOAD(a_load), .SHEN(a_shen),
        .READY(a_ready), .SO(a_so), .SO_VALID(a_valid), .LAST(a_last)
    );

    piso_shift_register #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .CLK(CLK), .SRCLR_N(b_rst_n), .PI(b_pi), .LOAD(b_load), .SHEN(b_shen),
        .READY(b_ready), .SO(b_so), .SO_VALID(b_valid), .LAST(b_last)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic       load;
        logic       shen;
        logic [3:0] pi;
        logic       ready;
        logic       so;
        logic       valid;
        logic       last;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst_n, input logic load, input logic shen,
                       input logic [3:0] pi, input logic ready, input logic so,
                       input logic valid, input logic last);
        vec_t v;
        v.rst_n = rst_n; v.load = load; v.shen = shen; v.pi = pi;
        v.ready = ready; v.so = so; v.valid = valid; v.last = last;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_b(input int idx, input logic ready, input logic so,
                           input logic valid, input logic last);
        check("lsb.READY", idx, b_ready, ready);
        check("lsb.SO", idx, b_so, so);
        check("lsb.SO_VALID", idx, b_valid, valid);
        check("lsb.LAST", idx, b_last, last);
    endtask

    initial begin
        logic [3:0] lsb_exp;
        n_vec = 0;
        n_err = 0;

        //   rst ld sh  pi       rdy so vld last
        add(1, 0, 1, 4'b0000, 1, 0, 0, 0);  // reset state, LOAD during reset discarded
        // single word 1011
        add(1, 1, 1, 4'b1011, 1, 0, 0, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 1, 1, 1, 1);
        // back-to-back 1100 then 0011
        add(1, 1, 1, 4'b1100, 1, 0, 0, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        add(1, 1, 1, 4'b0011, 1, 0, 1, 1);
        add(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 1, 1, 1, 1);
        // stall on bit 2 of 1011
        add(1, 1, 1, 4'b1011, 1, 0, 0, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(1, 0, 0, 4'b0000, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 1, 1, 1, 1);
        // ignored load of 0000 during bit 2 of 1111
        add(1, 1, 1, 4'b1111, 1, 0, 0, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 1, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 1, 1, 1, 1);
        add(1, 0, 1, 4'b0000, 1, 0, 0, 0);
        // reset mid-word, then 1001 sent normally
        add(1, 1, 1, 4'b1011, 1, 0, 0, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(0, 1, 1, 4'b1111, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 1, 0, 0, 0);
        add(1, 1, 1, 4'b1001, 1, 0, 0, 0);
        add(1, 0, 1, 4'b0000, 0, 1, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        add(1, 0, 1, 4'b0000, 1, 1, 1, 1);
        add(1, 0, 1, 4'b0000, 1, 0, 0, 0);

        // Hold both instances in reset with LOAD asserted for one edge.
        a_rst_n = 1'b0; a_load = 1'b1; a_shen = 1'b1; a_pi = 4'b1111;
        b_rst_n = 1'b0; b_load = 1'b1; b_shen = 1'b1; b_pi = 4'b1111;
        @(negedge CLK);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            a_rst_n = tbl[i].rst_n;
            a_load  = tbl[i].load;
            a_shen  = tbl[i].shen;
            a_pi    = tbl[i].pi;
            #1;
            check("msb.READY", i, a_ready, tbl[i].ready);
            check("msb.SO", i, a_so, tbl[i].so);
            check("msb.SO_VALID", i, a_valid, tbl[i].valid);
            check("msb.LAST", i, a_last, tbl[i].last);
        end

        // LSB-first instance: still in reset here, then send 1011 -> 1,1,0,1.
        #1;
        check_b(0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        b_rst_n = 1'b1; b_load = 1'b1; b_pi = 4'b1011; b_shen = 1'b1;
        #1;
        check_b(1, 1'b1, 1'b0, 1'b0, 1'b0);
        lsb_exp = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            b_load = 1'b0; b_pi = 4'b0000;
            #1;
            check_b(2 + k, (k == 3), lsb_exp[k], 1'b1, (k == 3));
        end
        @(negedge CLK);
        #1;
        check_b(6, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
